fir_serial_n: RTL

Parametrised, time-multiplexed FIR filter: a single multiply-accumulate unit iterates over `TAPS` coefficients per accepted sample. It replaces the fixed 3-tap, free-running-timer filter. New features are a valid/ready input handshake, a runtime-programmable, double-buffered coefficient bank, and a saturated, registered output with an overflow flag. It sits between the sample source and downstream consumers in the DSP chain.

---
 rtl/fir_pkg.sv | 31 +++
 rtl/fir_mac.sv | 35 +++
 rtl/fir_serial_n.sv | 108 ++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// fir_pkg: shared widths, FSM states and output clamp
// for the time-multiplexed FIR filter.
package fir_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int COEF_W_DEF = 8;
  localparam int TAPS_DEF   = 3;
  localparam int OUT_W_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } state_t;

  // Returns {clamped, value}; callers keep the low out_w bits.
  function automatic logic [64:0] sat_to_out(
    input logic signed [63:0] v,
    input int                 out_w
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    if (out_w >= 64) return {1'b0, v};
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return {1'b1, hi};
    if (v < lo) return {1'b1, lo};
    return {1'b0, v};
  endfunction

endpackage

// File: rtl/fir_mac.sv
// fir_mac: registered signed multiply-accumulate
// with synchronous clear and enable.
module fir_mac
  import fir_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int COEF_W = COEF_W_DEF,
  parameter int ACC_W  = DATA_W_DEF + COEF_W_DEF + 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    en,
  input  logic [DATA_W-1:0]       a,
  input  logic [COEF_W-1:0]       b,
  output logic signed [ACC_W-1:0] acc
);

  localparam int PW = DATA_W + COEF_W;

  logic signed [PW-1:0] prod;

  assign prod = PW'($signed(a)) * PW'($signed(b));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + ACC_W'(prod);
    end
  end

endmodule

// File: rtl/fir_serial_n.sv
// fir_serial_n: serial FIR with valid/ready input,
// double-buffered coefficients and saturated output.
module fir_serial_n
  import fir_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int COEF_W = COEF_W_DEF,
  parameter int TAPS   = TAPS_DEF,
  parameter int ACC_W  = DATA_W + COEF_W + $clog2(TAPS),
  parameter int OUT_W  = OUT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     coef_we,
  input  logic [$clog2(TAPS)-1:0]  coef_addr,
  input  logic [COEF_W-1:0]        coef_data,
  output logic                     out_valid,
  output logic [OUT_W-1:0]         out_data,
  output logic                     out_sat
);

  localparam int IW = $clog2(TAPS);
  localparam logic [IW-1:0] LAST = IW'(TAPS - 1);

  state_t                  state;
  logic [IW-1:0]           idx;
  logic [DATA_W-1:0]       x     [TAPS];
  logic [COEF_W-1:0]       s     [TAPS];
  logic [COEF_W-1:0]       c     [TAPS];
  logic [COEF_W-1:0]       s_nxt [TAPS];
  logic signed [ACC_W-1:0] acc;
  logic [64:0]             sat_r;
  logic                    unused_sat;
  logic                    accept;

  assign in_ready   = (state == IDLE);
  assign accept     = in_ready && in_valid;
  assign sat_r      = sat_to_out(64'(acc), OUT_W);
  assign unused_sat = ^sat_r[63:OUT_W];

  // A write landing on the accept edge is folded into the commit.
  always_comb begin
    s_nxt = s;
    if (coef_we && (int'(coef_addr) < TAPS)) begin
      s_nxt[coef_addr] = coef_data;
    end
  end

  fir_mac #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .en    (state == MAC),
    .a     (x[idx]),
    .b     (c[idx]),
    .acc   (acc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
      for (int k = 0; k < TAPS; k++) begin
        x[k] <= '0;
        s[k] <= '0;
        c[k] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      s         <= s_nxt;
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            x[0] <= in_data;
            for (int k = 1; k < TAPS; k++) begin
              x[k] <= x[k-1];
            end
            c     <= s_nxt;
            idx   <= '0;
            state <= MAC;
          end
        end
        MAC: begin
          idx <= idx + 1'b1;
          if (idx == LAST) state <= OUT;
        end
        OUT: begin
          out_data  <= sat_r[OUT_W-1:0];
          out_sat   <= sat_r[64];
          out_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
